// File: rtl/dm_pkg.sv
// Shared definitions for the byte-wide data memory path: access FSM states,
// word/byte geometry and big-endian byte lane helpers.
package dm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } dm_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = $clog2(BYTES_PER_WORD);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BYTES_PER_WORD - 1);

  // Big-endian lane select: byte 0 is bits 31:24, byte 3 is bits 7:0.
  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [BEAT_W-1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Big-endian lane insert: replaces byte k of word with b.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [BEAT_W-1:0] k,
                                              input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (k)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dm_byte_master.sv
// Word-to-byte access sequencer: splits one 32-bit load/store into four
// big-endian byte beats on a byte RAM port with a one-cycle registered read.
// Optional build macro DM_BYTE_MASTER_ALIGN_CHECK_EN rejects requests whose
// address is not word aligned (o_err pulse, no memory beats); without it
// unaligned words are accessed as-is and o_err is constant 0.
module dm_byte_master
  import dm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata
);

  // The load capture schedule assumes read data arrives exactly one cycle
  // after the address; any other latency would assemble the wrong bytes.
  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("dm_byte_master: only RD_LAT == 1 is supported");
  end

  dm_state_t           r_state, w_state_n;
  logic [BEAT_W-1:0]   r_cnt, w_cnt_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [31:0]         r_wdata, w_wdata_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic [31:0]         r_rdata, w_rdata_n;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_n;
  logic                r_mem_we, w_mem_we_n;
  logic [7:0]          r_mem_wdata, w_mem_wdata_n;

  logic [BEAT_W-1:0]   w_beat_next;
  logic [BEAT_W-1:0]   w_beat_prev;
  logic [ADDR_W-1:0]   w_addr_next;
  logic                w_misalign;

  assign w_beat_next = r_cnt + 1'b1;
  assign w_beat_prev = r_cnt - 1'b1;
  // Wraps naturally modulo 2^ADDR_W.
  assign w_addr_next = r_addr + ADDR_W'(w_beat_next);

`ifdef DM_BYTE_MASTER_ALIGN_CHECK_EN
  logic r_err;

  assign w_misalign = |i_addr[1:0];

  // One-cycle error pulse for a rejected misaligned request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && i_req && w_misalign;
    end
  end

  assign o_err = r_err;
`else
  assign w_misalign = 1'b0;
  assign o_err      = 1'b0;
`endif

  // Next-state, beat sequencing and next values of every registered output.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_busy_n      = r_busy;
    w_done_n      = 1'b0;
    w_rdata_n     = r_rdata;
    w_mem_addr_n  = r_mem_addr;
    w_mem_we_n    = 1'b0;
    w_mem_wdata_n = r_mem_wdata;

    case (r_state)
      IDLE: begin
        w_busy_n = 1'b0;
        if (i_req && !w_misalign) begin
          // Accept: beat 0 is presented in the very next cycle.
          w_state_n    = i_we ? WR : RD;
          w_cnt_n      = '0;
          w_addr_n     = i_addr;
          w_wdata_n    = i_wdata;
          w_busy_n     = 1'b1;
          w_mem_addr_n = i_addr;
          w_mem_we_n   = i_we;
          if (i_we) begin
            w_mem_wdata_n = byte_of(i_wdata, '0);
          end
        end
      end

      WR: begin
        if (r_cnt == BEAT_LAST) begin
          w_state_n = DONE;
          w_done_n  = 1'b1;
        end else begin
          w_cnt_n       = w_beat_next;
          w_mem_addr_n  = w_addr_next;
          w_mem_we_n    = 1'b1;
          w_mem_wdata_n = byte_of(r_wdata, w_beat_next);
        end
      end

      RD: begin
        // Data on i_mem_rdata now belongs to the previous beat's address.
        if (r_cnt != '0) begin
          w_rdata_n = insert_byte(r_rdata, w_beat_prev, i_mem_rdata);
        end
        if (r_cnt == BEAT_LAST) begin
          w_state_n = DRAIN;
        end else begin
          w_cnt_n      = w_beat_next;
          w_mem_addr_n = w_addr_next;
        end
      end

      DRAIN: begin
        w_rdata_n = insert_byte(r_rdata, BEAT_LAST, i_mem_rdata);
        w_state_n = DONE;
        w_done_n  = 1'b1;
      end

      DONE: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
        w_cnt_n   = '0;
      end

      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
        w_cnt_n   = '0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset wins over a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_rdata     <= w_rdata_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_wdata <= w_mem_wdata_n;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dm_byte_master.sv
// Bench for dm_byte_master: byte RAM with one-cycle registered read, a
// table of word accesses, write-beat/done scoreboard, and hand sequences for
// reset mid-store, a held request and (when built with the macro) alignment.
module tb_dm_byte_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wbeat_t;

  typedef struct {
    logic        we;
    logic [31:0] rd;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
  } vec_t;

  wbeat_t wq[$];
  done_t  dq[$];
  vec_t   tbl[$];
  logic [31:0] last_rd = 32'h0;

  logic [7:0] ram [logic [31:0]];

  dm_byte_master #(.ADDR_W(32), .RD_LAT(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM: registered read of the presented address, write on strobe.
  always @(posedge clk) begin
    mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
    if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every write beat and every done pulse must be expected.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        wbeat_t wb;
        wb = wq.pop_front();
        chk("wr_addr", mem_addr, wb.a);
        chk("wr_data", {24'h0, mem_wdata}, {24'h0, wb.d});
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        done_t dr;
        dr = dq.pop_front();
        if (!dr.we) chk("load_rdata", rdata, dr.rd);
      end
    end
  end

  task automatic push_beats(input logic [31:0] a, input logic [31:0] d, input int nb);
    for (int k = 0; k < nb; k++)
      wq.push_back(wbeat_t'{a + 32'(k), 8'(d >> (24 - 8*k))});
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    int lat;
    int exp_lat;
    lat = 0;
    exp_lat = w ? 5 : 6;
    if (w) push_beats(a, d, 4);
    dq.push_back(done_t'{w, exp_rd});
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (n <= 4) begin
        chk("beat_addr", mem_addr, a + 32'(n - 1));
        chk("beat_we", {31'h0, mem_we}, {31'h0, w});
      end
      if (n == 1) chk("err_low", {31'h0, err}, 32'h0);
      chk("busy_during", {31'h0, busy}, 32'h1);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (w) chk("store_keeps_rdata", rdata, last_rd);
    else last_rd = exp_rd;
    @(negedge clk);
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("done_after", {31'h0, done}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    tbl.push_back(vec_t'{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0100, 32'h0,         32'hA5A5_5A5A});
`ifndef DM_BYTE_MASTER_ALIGN_CHECK_EN
    tbl.push_back(vec_t'{1'b1, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0102_0304});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0013, 32'h0,         32'hEF00_0000});
`endif
    tbl.push_back(vec_t'{1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {31'h0, busy},   32'h0);
    chk("rst_done",  {31'h0, done},   32'h0);
    chk("rst_err",   {31'h0, err},    32'h0);
    chk("rst_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_rdata", rdata,           32'h0);
    chk("rst_maddr", mem_addr,        32'h0);
    chk("rst_wdata", {24'h0, mem_wdata}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      access(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rd);

    // Reset during beat 1 of a store: beats 0 and 1 land, 2 and 3 do not.
    push_beats(32'h40, 32'h1122_3344, 2);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we",    {31'h0, mem_we}, 32'h0);
    chk("midrst_busy",  {31'h0, busy},   32'h0);
    chk("midrst_done",  {31'h0, done},   32'h0);
    chk("midrst_rdata", rdata,           32'h0);
    chk("midrst_maddr", mem_addr,        32'h0);
    rst = 1'b0;
    last_rd = 32'h0;
    access(1'b0, 32'h40, 32'h0, 32'h1122_AAAA);

    // Request held high: one store completes, the next is accepted only in IDLE.
    push_beats(32'h50, 32'hCAFE_F00D, 4);
    push_beats(32'h50, 32'hCAFE_F00D, 4);
    dq.push_back(done_t'{1'b1, 32'h0});
    dq.push_back(done_t'{1'b1, 32'h0});
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h50; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    dcount = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      if (n <= 5) chk("hold_busy", {31'h0, busy}, 32'h1);
      else        chk("hold_idle_busy", {31'h0, busy}, 32'h0);
    end
    chk("hold_done_count", 32'(dcount), 32'd1);
    @(negedge clk);
    chk("hold_reaccept_busy", {31'h0, busy},   32'h1);
    chk("hold_reaccept_we",   {31'h0, mem_we}, 32'h1);
    chk("hold_reaccept_addr", mem_addr,        32'h50);
    req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("hold_second_done", {31'h0, done}, 32'h1);
    @(negedge clk);

`ifdef DM_BYTE_MASTER_ALIGN_CHECK_EN
    // Misaligned request is rejected with a single error pulse.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h21; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("align_err",  {31'h0, err},    32'h1);
    chk("align_busy", {31'h0, busy},   32'h0);
    chk("align_we",   {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("align_err_clear", {31'h0, err}, 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("align_no_done", {31'h0, done | mem_we | busy}, 32'h0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/dm_byte_master.md
Name: dm_byte_master

Overview:
- Initiator-side word access sequencer that sits between the single-cycle core's load/store path and a byte-wide data memory port.
- Turns one 32-bit load or store request into four sequential byte transfers, big-endian: byte at address A carries bits 31:24, A+3 carries bits 7:0.
- Returns the assembled load word with a done pulse.
- Lets the data memory be built as a plain byte RAM with one registered read port.

Parameters:
- ADDR_W, 32, width of word and byte addresses.
- RD_LAT, 1, byte-memory read latency in cycles; only value 1 is supported, and the block checks this at elaboration.

Ports:
- i_clk  input  1  clock, all logic on posedge.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  1  access request; sampled only in IDLE.
- i_we  input  1  1 = store, 0 = load; sampled with i_req.
- i_addr  input  ADDR_W  byte address of word; sampled with i_req.
- i_wdata  input  32  store data; sampled with i_req.
- o_busy  output  1  high from the cycle after accept through the DONE cycle.
- o_done  output  1  one-cycle pulse when the access completes.
- o_err  output  1  one-cycle pulse on a rejected misaligned request (ALIGN_CHECK_EN only).
- o_rdata  output  32  assembled load word; valid with o_done, held until the next load completes.
- o_mem_addr  output  ADDR_W  byte address to the memory.
- o_mem_we  output  1  byte write strobe.
- o_mem_wdata  output  8  byte write data.
- i_mem_rdata  input  8  byte read data; returns RD_LAT cycles after the address is presented.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_busy, o_done, o_err, o_mem_we = 0.
  - o_rdata, o_mem_addr, o_mem_wdata = 0.
  - State = IDLE; beat counter = 0.
- FSM states: IDLE, WR, RD, DRAIN, DONE.
- Accept rule: in IDLE, i_req=1 at edge T latches i_we, i_addr and i_wdata. Requests while busy are ignored, with no queueing.
- Store (IDLE -> WR), cycles T+1..T+4:
  - o_mem_we=1, o_mem_addr = A+k, o_mem_wdata = byte k, for k = 0..3.
  - Byte k is i_wdata[31-8k -: 8].
  - T+5: DONE, o_done=1, o_mem_we=0.
- Load (IDLE -> RD), cycles T+1..T+4:
  - o_mem_we=0, o_mem_addr = A+k.
  - The byte for beat k appears on i_mem_rdata in the following cycle and is captured into o_rdata[31-8k -: 8].
  - T+5: DRAIN captures the last byte.
  - T+6: DONE with o_done=1; o_rdata is complete at this point.
- Store latency is 5 cycles and load latency is 6 cycles, both counted from accept to o_done.
- DONE -> IDLE unconditionally. A request presented during DONE is not accepted; the earliest next accept is the first IDLE cycle.
- o_busy=1 in WR, RD, DRAIN and DONE.
- Address arithmetic is modulo 2^ADDR_W: A = 0xFFFFFFFE gives beats FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- o_rdata is updated byte-wise during RD/DRAIN. Consumers read it only at o_done, and it is otherwise stable between loads. Stores never modify o_rdata.
- Reset mid-operation:
  - Next edge returns to IDLE with o_mem_we=0 and outputs at their reset values.
  - Bytes already written stay written; no rollback.
- Simultaneous i_rst and i_req: reset wins, and the request is dropped.

Optional Feature:
- Macro: DM_BYTE_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request with i_addr[1:0] != 0 is not performed and stays in IDLE.
  - o_err pulses for one cycle at T+1; no memory beats and no o_done.
- Undefined:
  - Unaligned addresses are performed as-is, with beats A..A+3 wrapping mod 2^ADDR_W.
  - o_err is tied to 0.

Decomposition:
- Shared package dm_pkg:
  - State enum (IDLE, WR, RD, DRAIN, DONE).
  - BYTES_PER_WORD = 4.
  - Beat-counter width.
  - Function byte_of(word, k) returning the big-endian byte k.
  - The data-memory module and this block both use the package.
- No sub-module: the byte lane select/insert is the package function, and the FSM plus counter stays in one module.

Test Plan:
- Store A=0x10, D=0xDEADBEEF -> beats T+1..T+4: addr 10,11,12,13, we=1, data DE,AD,BE,EF; o_done at T+5; o_busy high T+1..T+5.
- Load A=0x10 after that store, bench byte RAM with 1-cycle read -> addrs 10..13 on T+1..T+4, we=0; o_done at T+6 with o_rdata=0xDEADBEEF.
- Wrap: store 0x01020304 at A=0xFFFFFFFE (macro undefined) -> addrs FFFFFFFE, FFFFFFFF, 0, 1 with data 01,02,03,04; load back returns 0x01020304.
- Misaligned A=0x21 with ALIGN_CHECK_EN -> o_err=1 at T+1 only, o_mem_we never asserted, no o_done, back in IDLE.
- i_req held high through a store plus 3 cycles -> exactly one store done; second request accepted in the first IDLE cycle (T+6), not during DONE.
- i_rst asserted at T+2 of a store -> at T+3 o_mem_we=0 and o_busy=0; bytes A and A+1 written, A+2 and A+3 unchanged.
